// File: rtl/rmii_rx_framer.sv
// rmii_rx_framer: RMII receive framer.
//
// Consumes two dibits per mii_clk cycle from the RMII IDDR capture, strips the
// preamble/SFD at either dibit alignment, reassembles bytes (LSB first on the
// wire), checks CRC-32 and frame length, and presents a byte stream with
// start/end/status strobes to the command parser.
//
// Optional build macro: RMII_RX_FCS_STRIP_EN
//   defined   - bytes pass through a 4-byte delay line so the FCS is never
//               emitted; rx_len excludes the FCS (length checks still include it).
//   undefined - every byte, FCS included, is emitted.
//
// Ports:
//   mii_clk   in   1  RMII-derived clock, two dibits per cycle
//   rst_n     in   1  asynchronous active-low reset
//   rmii_D    in   4  dibits; [1:0] earlier on the wire, [3:2] later
//   rmii_DV   in   2  CRS_DV; [0] qualifies rmii_D[1:0], [1] qualifies rmii_D[3:2]
//   rx_data   out  8  assembled byte
//   rx_valid  out  1  one-cycle strobe, rx_data valid
//   rx_sof    out  1  with rx_valid on the first byte of a frame
//   rx_eof    out  1  one-cycle end-of-frame strobe, never with rx_valid
//   rx_good   out  1  with rx_eof: FCS ok, length in range, whole bytes
//   rx_len    out  11 with rx_eof: byte count, saturating at MAX_LEN
module rmii_rx_framer #(
    parameter int unsigned MIN_LEN      = 64,
    parameter int unsigned MAX_LEN      = 1522,
    parameter int unsigned MIN_PREAMBLE = 6
) (
    input  logic        mii_clk,
    input  logic        rst_n,
    input  logic [3:0]  rmii_D,
    input  logic [1:0]  rmii_DV,
    output logic [7:0]  rx_data,
    output logic        rx_valid,
    output logic        rx_sof,
    output logic        rx_eof,
    output logic        rx_good,
    output logic [10:0] rx_len
);

    localparam logic [10:0] MinLen     = 11'(MIN_LEN);
    localparam logic [10:0] MaxLen     = 11'(MAX_LEN);
    localparam logic [3:0]  MinPre     = 4'(MIN_PREAMBLE);
    localparam logic [31:0] CrcPoly    = 32'hEDB88320;  // 0x04C11DB7 reflected
    localparam logic [31:0] CrcResidue = 32'hDEBB20E3;

    typedef enum logic [2:0] {StIdle, StPreamble, StData, StTrunc, StDrop} state_e;

    state_e      state_q, state_d;
    logic [3:0]  pre_cnt_q, pre_cnt_d;
    logic [31:0] crc_q, crc_d;
    logic [10:0] cnt_q, cnt_d;
    logic [1:0]  phase_q, phase_d;
    logic [7:0]  shreg_q, shreg_d;
`ifdef RMII_RX_FCS_STRIP_EN
    logic [3:0][7:0] dly_q, dly_d;
`endif
    logic [7:0]  data_q, data_d;
    logic        valid_q, valid_d;
    logic        sof_q, sof_d;
    logic        eof_q, eof_d;
    logic        good_q, good_d;
    logic [10:0] len_q, len_d;
    logic [1:0]  dib;
    logic [7:0]  byte_val;

    // Reflected CRC-32 advanced by one dibit, bit 0 first.
    function automatic logic [31:0] crc_dibit(input logic [31:0] crc, input logic [1:0] d);
        logic [31:0] c;
        c = crc;
        for (int b = 0; b < 2; b++) begin
            c = (c[0] ^ d[b]) ? ((c >> 1) ^ CrcPoly) : (c >> 1);
        end
        return c;
    endfunction

    always_comb begin
        state_d   = state_q;
        pre_cnt_d = pre_cnt_q;
        crc_d     = crc_q;
        cnt_d     = cnt_q;
        phase_d   = phase_q;
        shreg_d   = shreg_q;
`ifdef RMII_RX_FCS_STRIP_EN
        dly_d     = dly_q;
`endif
        data_d    = 8'h00;
        valid_d   = 1'b0;
        sof_d     = 1'b0;
        eof_d     = 1'b0;
        good_d    = 1'b0;
        len_d     = 11'd0;
        dib       = 2'b00;
        byte_val  = 8'h00;

        if (rmii_DV == 2'b00) begin
            // End of carrier; only frames that reached the SFD report an eof.
            if (state_q == StData || state_q == StTrunc) begin
                eof_d  = 1'b1;
                good_d = (state_q == StData) && (crc_q == CrcResidue) &&
                         (cnt_q >= MinLen) && (phase_q == 2'd0);
`ifdef RMII_RX_FCS_STRIP_EN
                len_d  = (cnt_q >= 11'd4) ? (cnt_q - 11'd4) : 11'd0;
`else
                len_d  = cnt_q;
`endif
            end
            state_d = StIdle;
        end else begin
            // Walk both slots in wire order so the SFD may sit in either one.
            for (int s = 0; s < 2; s++) begin
                if (rmii_DV[s]) begin
                    dib = rmii_D[2*s +: 2];
                    case (state_d)
                        StIdle: begin
                            if (dib == 2'b01) begin
                                state_d   = StPreamble;
                                pre_cnt_d = 4'd1;
                            end else begin
                                state_d = StDrop;
                            end
                        end
                        StPreamble: begin
                            if (dib == 2'b01) begin
                                if (pre_cnt_d != 4'hF) pre_cnt_d = pre_cnt_d + 4'd1;
                            end else if (dib == 2'b11 && pre_cnt_d >= MinPre) begin
                                state_d = StData;
                                crc_d   = 32'hFFFFFFFF;
                                cnt_d   = 11'd0;
                                phase_d = 2'd0;
                            end else begin
                                state_d = StDrop;
                            end
                        end
                        StData: begin
                            crc_d    = crc_dibit(crc_d, dib);
                            byte_val = {dib, shreg_d[7:2]};
                            shreg_d  = byte_val;
                            if (phase_d == 2'd3) begin
                                if (cnt_d == MaxLen) begin
                                    state_d = StTrunc;
                                end else begin
`ifdef RMII_RX_FCS_STRIP_EN
                                    // Emit the byte received four bytes ago.
                                    if (cnt_d >= 11'd4) begin
                                        valid_d = 1'b1;
                                        data_d  = dly_d[3];
                                        sof_d   = (cnt_d == 11'd4);
                                    end
                                    dly_d = {dly_d[2:0], byte_val};
`else
                                    valid_d = 1'b1;
                                    data_d  = byte_val;
                                    sof_d   = (cnt_d == 11'd0);
`endif
                                    cnt_d = cnt_d + 11'd1;
                                end
                            end
                            phase_d = phase_d + 2'd1;
                        end
                        default: ;  // StTrunc/StDrop ignore data until carrier drops
                    endcase
                end
            end
        end
    end

    always_ff @(posedge mii_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            pre_cnt_q <= 4'd0;
            crc_q     <= 32'hFFFFFFFF;
            cnt_q     <= 11'd0;
            phase_q   <= 2'd0;
            shreg_q   <= 8'h00;
`ifdef RMII_RX_FCS_STRIP_EN
            dly_q     <= '0;
`endif
            data_q    <= 8'h00;
            valid_q   <= 1'b0;
            sof_q     <= 1'b0;
            eof_q     <= 1'b0;
            good_q    <= 1'b0;
            len_q     <= 11'd0;
        end else begin
            state_q   <= state_d;
            pre_cnt_q <= pre_cnt_d;
            crc_q     <= crc_d;
            cnt_q     <= cnt_d;
            phase_q   <= phase_d;
            shreg_q   <= shreg_d;
`ifdef RMII_RX_FCS_STRIP_EN
            dly_q     <= dly_d;
`endif
            data_q    <= data_d;
            valid_q   <= valid_d;
            sof_q     <= sof_d;
            eof_q     <= eof_d;
            good_q    <= good_d;
            len_q     <= len_d;
        end
    end

    assign rx_data  = data_q;
    assign rx_valid = valid_q;
    assign rx_sof   = sof_q;
    assign rx_eof   = eof_q;
    assign rx_good  = good_q;
    assign rx_len   = len_q;

endmodule
